// File: rtl/e203_exu_flush_arb.sv
// Fixed-priority flush arbiter onto the IFU flush port, plus instret counter and flush-ack watchdog.
// Grant/ops are combinational (0-cycle); an un-acked grant locks until ack or the source withdraws.
module e203_exu_flush_arb #(
  parameter int NSRC    = 3,
  parameter int PC_W    = 32,
  parameter int CMT_W   = 2,
  parameter int CNT_W   = 64,
  parameter int TMO_CYC = 1024,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        src_flush_req,
  input  logic [NSRC*PC_W-1:0]   src_flush_op1,
  input  logic [NSRC*PC_W-1:0]   src_flush_op2,
  output logic [NSRC-1:0]        src_flush_ack,
  output logic                   pipe_flush_req,
  input  logic                   pipe_flush_ack,
  output logic [PC_W-1:0]        pipe_flush_add_op1,
  output logic [PC_W-1:0]        pipe_flush_add_op2,
  output logic [ID_W-1:0]        flush_src_id,
  output logic                   flush_pulse,
  input  logic [CMT_W-1:0]       cmt_valid,
  input  logic [CMT_W-1:0]       cmt_kill,
  output logic [CNT_W-1:0]       instret_cnt,
  output logic                   tmo_flag,
  input  logic                   tmo_clr
);

  localparam int TC_W = $clog2(TMO_CYC) + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [ID_W-1:0] lock_id;
  logic [TC_W-1:0] tmo_cnt;

  logic [ID_W-1:0]  prio_id;
  logic [ID_W-1:0]  gid;
  logic             any_req;
  logic             held;
  logic             fire;
  logic             tmo_set;
  logic [CNT_W-1:0] inc;

  // Lowest index wins; iterate downward so the last assignment is the winner.
  always_comb begin
    prio_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_flush_req[i]) prio_id = ID_W'(i);
    end
  end

  always_comb begin
    any_req = |src_flush_req;
    held    = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (lock_id == ID_W'(i)) held = src_flush_req[i];
    end
    gid            = (state == LOCKED) ? lock_id : prio_id;
    pipe_flush_req = (state == LOCKED) ? held : any_req;
    fire           = pipe_flush_req & pipe_flush_ack;
    flush_pulse    = fire;
  end

  always_comb begin
    src_flush_ack      = '0;
    pipe_flush_add_op1 = '0;
    pipe_flush_add_op2 = '0;
    flush_src_id       = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (gid == ID_W'(i)) begin
        src_flush_ack[i] = fire;
        if (pipe_flush_req) begin
          pipe_flush_add_op1 = src_flush_op1[i*PC_W +: PC_W];
          pipe_flush_add_op2 = src_flush_op2[i*PC_W +: PC_W];
          flush_src_id       = gid;
        end
      end
    end
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < CMT_W; i++) begin
      if (cmt_valid[i] && !cmt_kill[i]) inc = inc + CNT_W'(1);
    end
  end

  assign tmo_set = (state == LOCKED) && held && !pipe_flush_ack &&
                   (tmo_cnt == TC_W'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lock_id     <= '0;
      tmo_cnt     <= '0;
      tmo_flag    <= 1'b0;
      instret_cnt <= '0;
    end else begin
      instret_cnt <= instret_cnt + inc;
      case (state)
        IDLE: begin
          if (any_req && !pipe_flush_ack) begin
            lock_id <= prio_id;
            tmo_cnt <= TC_W'(1);
            state   <= LOCKED;
          end
        end
        default: begin
          if (!held || pipe_flush_ack) begin
            tmo_cnt <= '0;
            state   <= IDLE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TC_W'(1);
          end
        end
      endcase
      // A set in the same cycle as a clear must win.
      if (tmo_set) tmo_flag <= 1'b1;
      else if (tmo_clr) tmo_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Directed bench for e203_exu_flush_arb with TMO_CYC=8 and CNT_W=4.
module tb_e203_exu_flush_arb;

  localparam int NSRC = 3, PC_W = 32, CMT_W = 2, CNT_W = 4, TMO_CYC = 8, ID_W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSRC-1:0]      src_flush_req;
  logic [NSRC*PC_W-1:0] src_flush_op1;
  logic [NSRC*PC_W-1:0] src_flush_op2;
  logic [NSRC-1:0]      src_flush_ack;
  logic                 pipe_flush_req;
  logic                 pipe_flush_ack;
  logic [PC_W-1:0]      pipe_flush_add_op1;
  logic [PC_W-1:0]      pipe_flush_add_op2;
  logic [ID_W-1:0]      flush_src_id;
  logic                 flush_pulse;
  logic [CMT_W-1:0]     cmt_valid;
  logic [CMT_W-1:0]     cmt_kill;
  logic [CNT_W-1:0]     instret_cnt;
  logic                 tmo_flag;
  logic                 tmo_clr;

  int tests = 0;
  int fails = 0;

  localparam logic [PC_W-1:0] OP1_0 = 32'h0000_1000, OP1_1 = 32'h8000_0000, OP1_2 = 32'h2000_0000;
  localparam logic [PC_W-1:0] OP2_0 = 32'h0000_0010, OP2_1 = 32'h0000_0004, OP2_2 = 32'h0000_0100;

  e203_exu_flush_arb #(
    .NSRC(NSRC), .PC_W(PC_W), .CMT_W(CMT_W), .CNT_W(CNT_W), .TMO_CYC(TMO_CYC), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .src_flush_req(src_flush_req), .src_flush_op1(src_flush_op1), .src_flush_op2(src_flush_op2),
    .src_flush_ack(src_flush_ack), .pipe_flush_req(pipe_flush_req), .pipe_flush_ack(pipe_flush_ack),
    .pipe_flush_add_op1(pipe_flush_add_op1), .pipe_flush_add_op2(pipe_flush_add_op2),
    .flush_src_id(flush_src_id), .flush_pulse(flush_pulse),
    .cmt_valid(cmt_valid), .cmt_kill(cmt_kill), .instret_cnt(instret_cnt),
    .tmo_flag(tmo_flag), .tmo_clr(tmo_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_flush_req = '0; pipe_flush_ack = 1'b0;
    cmt_valid = '0; cmt_kill = '0; tmo_clr = 1'b0;
    src_flush_op1 = {OP1_2, OP1_1, OP1_0};
    src_flush_op2 = {OP2_2, OP2_1, OP2_0};
    tick(); tick();
    rst = 1'b0;
    #1;
    tests++; if (pipe_flush_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", pipe_flush_req); end
    tests++; if (src_flush_ack !== 3'b000) begin fails++; $display("FAIL reset_ack got %b want 000", src_flush_ack); end
    tests++; if (flush_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse got %b want 0", flush_pulse); end
    tests++; if (pipe_flush_add_op1 !== '0 || pipe_flush_add_op2 !== '0 || flush_src_id !== '0) begin
      fails++; $display("FAIL reset_ops got %h %h %0d want 0 0 0", pipe_flush_add_op1, pipe_flush_add_op2, flush_src_id); end
    tests++; if (instret_cnt !== 4'd0) begin fails++; $display("FAIL reset_instret got %0d want 0", instret_cnt); end
    tests++; if (tmo_flag !== 1'b0) begin fails++; $display("FAIL reset_tmo got %b want 0", tmo_flag); end
  endtask

  task automatic test_single_ack();
    src_flush_req = 3'b010; pipe_flush_ack = 1'b1;
    #1;
    tests++; if (pipe_flush_req !== 1'b1) begin fails++; $display("FAIL single_req got %b want 1", pipe_flush_req); end
    tests++; if (pipe_flush_add_op1 !== OP1_1 || pipe_flush_add_op2 !== OP2_1) begin
      fails++; $display("FAIL single_ops got %h %h want %h %h", pipe_flush_add_op1, pipe_flush_add_op2, OP1_1, OP2_1); end
    tests++; if (flush_src_id !== 2'd1) begin fails++; $display("FAIL single_id got %0d want 1", flush_src_id); end
    tests++; if (src_flush_ack !== 3'b010) begin fails++; $display("FAIL single_ack got %b want 010", src_flush_ack); end
    tests++; if (flush_pulse !== 1'b1) begin fails++; $display("FAIL single_pulse got %b want 1", flush_pulse); end
    tick();
    // Still IDLE: a new source-0 request must be granted immediately.
    src_flush_req = 3'b001; pipe_flush_ack = 1'b1;
    #1;
    tests++; if (flush_src_id !== 2'd0 || src_flush_ack !== 3'b001) begin
      fails++; $display("FAIL single_idle id %0d ack %b want 0 001", flush_src_id, src_flush_ack); end
    tick();
    src_flush_req = '0; pipe_flush_ack = 1'b0;
  endtask

  task automatic test_lock_hold();
    src_flush_req = 3'b100; pipe_flush_ack = 1'b0;
    #1;
    tests++; if (flush_src_id !== 2'd2 || src_flush_ack !== 3'b000) begin
      fails++; $display("FAIL lock_c1 id %0d ack %b want 2 000", flush_src_id, src_flush_ack); end
    tick();
    src_flush_req = 3'b101;
    #1;
    tests++; if (flush_src_id !== 2'd2 || pipe_flush_add_op1 !== OP1_2) begin
      fails++; $display("FAIL lock_c2 id %0d op1 %h want 2 %h", flush_src_id, pipe_flush_add_op1, OP1_2); end
    tick();
    #1;
    tests++; if (flush_src_id !== 2'd2 || pipe_flush_req !== 1'b1) begin
      fails++; $display("FAIL lock_c3 id %0d req %b want 2 1", flush_src_id, pipe_flush_req); end
    tick();
    pipe_flush_ack = 1'b1;
    #1;
    tests++; if (src_flush_ack !== 3'b100 || flush_pulse !== 1'b1) begin
      fails++; $display("FAIL lock_c4 ack %b pulse %b want 100 1", src_flush_ack, flush_pulse); end
    tick();
    src_flush_req = 3'b001;
    #1;
    tests++; if (flush_src_id !== 2'd0 || src_flush_ack !== 3'b001 || pipe_flush_add_op2 !== OP2_0) begin
      fails++; $display("FAIL lock_c5 id %0d ack %b op2 %h want 0 001 %h", flush_src_id, src_flush_ack, pipe_flush_add_op2, OP2_0); end
    tick();
    src_flush_req = '0; pipe_flush_ack = 1'b0;
  endtask

  task automatic test_priority();
    src_flush_req = 3'b011; pipe_flush_ack = 1'b1;
    #1;
    tests++; if (flush_src_id !== 2'd0 || src_flush_ack !== 3'b001) begin
      fails++; $display("FAIL prio_first id %0d ack %b want 0 001", flush_src_id, src_flush_ack); end
    tick();
    src_flush_req = 3'b010;
    #1;
    tests++; if (flush_src_id !== 2'd1 || src_flush_ack !== 3'b010 || pipe_flush_add_op1 !== OP1_1) begin
      fails++; $display("FAIL prio_second id %0d ack %b op1 %h want 1 010 %h", flush_src_id, src_flush_ack, pipe_flush_add_op1, OP1_1); end
    tick();
    src_flush_req = '0; pipe_flush_ack = 1'b0;
  endtask

  task automatic test_drop();
    src_flush_req = 3'b010; pipe_flush_ack = 1'b0;
    tick();
    src_flush_req = 3'b001; pipe_flush_ack = 1'b1;
    #1;
    tests++; if (pipe_flush_req !== 1'b0 || src_flush_ack !== 3'b000 || flush_pulse !== 1'b0) begin
      fails++; $display("FAIL drop_cycle req %b ack %b pulse %b want 0 000 0", pipe_flush_req, src_flush_ack, flush_pulse); end
    tests++; if (flush_src_id !== 2'd0 || pipe_flush_add_op1 !== '0) begin
      fails++; $display("FAIL drop_ops id %0d op1 %h want 0 0", flush_src_id, pipe_flush_add_op1); end
    tick();
    pipe_flush_ack = 1'b0;
    #1;
    tests++; if (pipe_flush_req !== 1'b1 || flush_src_id !== 2'd0) begin
      fails++; $display("FAIL drop_rearb req %b id %0d want 1 0", pipe_flush_req, flush_src_id); end
    tick();
    src_flush_req = '0;
    tick();
  endtask

  task automatic test_timeout();
    src_flush_req = 3'b100; pipe_flush_ack = 1'b0;
    for (int k = 0; k < TMO_CYC - 1; k++) tick();
    tests++; if (tmo_flag !== 1'b0) begin fails++; $display("FAIL tmo_early got %b want 0", tmo_flag); end
    tick();
    tests++; if (tmo_flag !== 1'b1) begin fails++; $display("FAIL tmo_set got %b want 1", tmo_flag); end
    pipe_flush_ack = 1'b1;
    tick();
    src_flush_req = '0; pipe_flush_ack = 1'b0;
    tick();
    tests++; if (tmo_flag !== 1'b1) begin fails++; $display("FAIL tmo_sticky got %b want 1", tmo_flag); end
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    tests++; if (tmo_flag !== 1'b0) begin fails++; $display("FAIL tmo_clear got %b want 0", tmo_flag); end
    src_flush_req = 3'b100;
    for (int k = 0; k < TMO_CYC - 1; k++) tick();
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    tests++; if (tmo_flag !== 1'b1) begin fails++; $display("FAIL tmo_set_wins got %b want 1", tmo_flag); end
    src_flush_req = '0;
    tick();
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
  endtask

  task automatic test_instret();
    cmt_valid = 2'b11; cmt_kill = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests++; if (instret_cnt !== 4'(k)) begin fails++; $display("FAIL instret_step%0d got %0d want %0d", k, instret_cnt, k); end
    end
    cmt_valid = '0; cmt_kill = '0;
    tick();
    tests++; if (instret_cnt !== 4'd5) begin fails++; $display("FAIL instret_hold got %0d want 5", instret_cnt); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmt_valid = 2'b11; cmt_kill = 2'b00;
    for (int k = 0; k < 7; k++) tick();
    cmt_valid = 2'b01;
    tick();
    tests++; if (instret_cnt !== 4'd15) begin fails++; $display("FAIL wrap_preload got %0d want 15", instret_cnt); end
    cmt_valid = 2'b11;
    tick();
    tests++; if (instret_cnt !== 4'd1) begin fails++; $display("FAIL wrap got %0d want 1", instret_cnt); end
    cmt_valid = '0;
  endtask

  task automatic test_reset_mid_lock();
    src_flush_req = 3'b010; pipe_flush_ack = 1'b0; cmt_valid = 2'b11;
    tick();
    rst = 1'b1; src_flush_req = '0; cmt_valid = '0;
    tick();
    tests++; if (pipe_flush_req !== 1'b0 || src_flush_ack !== 3'b000 || flush_pulse !== 1'b0 || flush_src_id !== 2'd0) begin
      fails++; $display("FAIL rstlock_out req %b ack %b pulse %b id %0d want 0", pipe_flush_req, src_flush_ack, flush_pulse, flush_src_id); end
    tests++; if (instret_cnt !== 4'd0 || tmo_flag !== 1'b0) begin
      fails++; $display("FAIL rstlock_state cnt %0d tmo %b want 0 0", instret_cnt, tmo_flag); end
    rst = 1'b0;
    src_flush_req = 3'b001;
    #1;
    tests++; if (pipe_flush_req !== 1'b1 || flush_src_id !== 2'd0) begin
      fails++; $display("FAIL rstlock_idle req %b id %0d want 1 0", pipe_flush_req, flush_src_id); end
    src_flush_req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_ack();
    test_lock_hold();
    test_priority();
    test_drop();
    test_timeout();
    test_instret();
    test_wrap();
    test_reset_mid_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
